motion_event_detector: RTL

Downstream consumer of the moving-average stage's smoothed outputs. Takes the three 2-bit window sums (x, y, t) with a sample-valid qualifier and detects sustained excursions. An excursion must hold at or above an on-level for a dwell of consecutive valid samples. The block then emits a one-cycle event with the winning axis and level, tracks the active excursion until it falls to an off-level (hysteresis), and enforces a hold-off before re-arming. It keeps a saturating event counter for readout.

---
 rtl/motion_event_detector_if.sv | 34 +++
 rtl/motion_event_detector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/motion_event_detector_if.sv
// rtl/motion_event_detector_if.sv - sample/event bundle between moving-average stage, detector and readout
// Purpose: groups the smoothed-sum inputs and the event/readout outputs of motion_event_detector.
// Signals:
//   in_valid           sample qualifier; the sums are only looked at while high
//   sum_x/sum_y/sum_t  2-bit unsigned smoothed window sums
//   clr_count          synchronous clear of event_count
//   event_pulse        one-cycle strobe per detected event
//   event_axis         axis of the last event (00=x, 01=y, 10=t)
//   event_level        peak value of the sample that fired the last event
//   active             high while an excursion is being tracked
//   event_count        saturating event counter
// Modports: master drives the samples and the clear, slave is the detector.
interface motion_event_detector_if;
    logic       in_valid;
    logic [1:0] sum_x;
    logic [1:0] sum_y;
    logic [1:0] sum_t;
    logic       clr_count;
    logic       event_pulse;
    logic [1:0] event_axis;
    logic [1:0] event_level;
    logic       active;
    logic [7:0] event_count;

    modport master (
        output in_valid, sum_x, sum_y, sum_t, clr_count,
        input  event_pulse, event_axis, event_level, active, event_count
    );

    modport slave (
        input  in_valid, sum_x, sum_y, sum_t, clr_count,
        output event_pulse, event_axis, event_level, active, event_count
    );
endinterface

// File: rtl/motion_event_detector.sv
// rtl/motion_event_detector.sv - sustained-excursion detector with hysteresis, hold-off and event counter
// Purpose: watches the three smoothed sums, fires a one-cycle event once one axis has stayed at or
// above ON_LEVEL for DWELL consecutive valid samples, tracks it until it drops to OFF_LEVEL, then
// waits HOLDOFF clocks before re-arming.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    motion_event_detector_if.slave (samples in, event/readout out)
module motion_event_detector #(
    parameter int unsigned ON_LEVEL  = 2,
    parameter int unsigned OFF_LEVEL = 1,
    parameter int unsigned DWELL     = 3,
    parameter int unsigned HOLDOFF   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    motion_event_detector_if.slave   bus
);

    localparam logic [1:0] ON_L    = 2'(ON_LEVEL);
    localparam logic [1:0] OFF_L   = 2'(OFF_LEVEL);
    localparam logic [3:0] DWELL_L = 4'(DWELL);
    localparam logic [7:0] HOLD_L  = 8'(HOLDOFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMING,
        S_ACTIVE,
        S_HOLDOFF
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] dwell_q, dwell_d;
    logic [7:0] holdoff_q, holdoff_d;
    logic [1:0] arm_axis_q, arm_axis_d;   // axis being tracked while arming/active
    logic       pulse_q, pulse_d;
    logic [1:0] ev_axis_q, ev_axis_d;     // axis of the last fired event only
    logic [1:0] ev_level_q, ev_level_d;
    logic [7:0] count_q, count_d;

    logic [1:0] peak;
    logic [1:0] win_axis;
    logic [1:0] tracked_val;
    logic       fire;
    logic [1:0] fire_axis;

    // Peak and winning axis; ties resolve towards the lowest index (x, then y, then t).
    always_comb begin
        peak     = bus.sum_x;
        win_axis = 2'd0;
        if (bus.sum_x >= bus.sum_y && bus.sum_x >= bus.sum_t) begin
            peak     = bus.sum_x;
            win_axis = 2'd0;
        end else if (bus.sum_y >= bus.sum_t) begin
            peak     = bus.sum_y;
            win_axis = 2'd1;
        end else begin
            peak     = bus.sum_t;
            win_axis = 2'd2;
        end
    end

    always_comb begin
        case (arm_axis_q)
            2'd0:    tracked_val = bus.sum_x;
            2'd1:    tracked_val = bus.sum_y;
            default: tracked_val = bus.sum_t;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        holdoff_d  = holdoff_q;
        arm_axis_d = arm_axis_q;
        pulse_d    = 1'b0;
        ev_axis_d  = ev_axis_q;
        ev_level_d = ev_level_q;
        count_d    = count_q;
        fire       = 1'b0;
        fire_axis  = arm_axis_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && peak >= ON_L) begin
                    arm_axis_d = win_axis;
                    dwell_d    = 4'd1;
                    fire_axis  = win_axis;
                    if (DWELL_L == 4'd1) fire = 1'b1;
                    else                 state_d = S_ARMING;
                end
            end
            S_ARMING: begin
                if (bus.in_valid) begin
                    // Staying high on the tracked axis takes priority over a new winner.
                    if (tracked_val >= ON_L) begin
                        dwell_d = dwell_q + 4'd1;
                        if (dwell_q + 4'd1 == DWELL_L) fire = 1'b1;
                    end else if (peak >= ON_L) begin
                        arm_axis_d = win_axis;
                        dwell_d    = 4'd1;
                        fire_axis  = win_axis;
                        if (DWELL_L == 4'd1) fire = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        dwell_d = 4'd0;
                    end
                end
            end
            S_ACTIVE: begin
                if (bus.in_valid && tracked_val <= OFF_L) begin
                    if (HOLD_L == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        holdoff_d = HOLD_L;
                        state_d   = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                // Runs on every clock; the cycle with holdoff==1 is the last one spent here.
                if (holdoff_q <= 8'd1) begin
                    holdoff_d = 8'd0;
                    state_d   = S_IDLE;
                end else begin
                    holdoff_d = holdoff_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            state_d    = S_ACTIVE;
            dwell_d    = 4'd0;
            pulse_d    = 1'b1;
            ev_axis_d  = fire_axis;
            ev_level_d = peak;
        end

        // A clear in the same cycle as a fire still counts that event.
        if (bus.clr_count)                    count_d = fire ? 8'd1 : 8'd0;
        else if (fire && count_q != 8'hFF)    count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dwell_q    <= 4'd0;
            holdoff_q  <= 8'd0;
            arm_axis_q <= 2'd0;
            pulse_q    <= 1'b0;
            ev_axis_q  <= 2'd0;
            ev_level_q <= 2'd0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            holdoff_q  <= holdoff_d;
            arm_axis_q <= arm_axis_d;
            pulse_q    <= pulse_d;
            ev_axis_q  <= ev_axis_d;
            ev_level_q <= ev_level_d;
            count_q    <= count_d;
        end
    end

    assign bus.event_pulse = pulse_q;
    assign bus.event_axis  = ev_axis_q;
    assign bus.event_level = ev_level_q;
    assign bus.active      = (state_q == S_ACTIVE);
    assign bus.event_count = count_q;

endmodule
